palette_lut_rw: RTL and testbench

- Parametrised, runtime-writable colour palette for the VGA/sprite pixel path; successor to the fixed 16-entry 12-bit palette.
- Maps a pixel index to RGB through a registered lookup pipeline.
- Adds a write port for palette updates and a global brightness scaler with a timed fade engine, used for screen fades.
- Sits between the sprite/tile index source and the VGA colour outputs.

---
 rtl/palette_pkg.sv | 18 +
 rtl/palette_fade_ctrl.sv | 93 +++++++++
 rtl/palette_lut_rw.sv | 108 ++++++++++
 tb/tb_palette_lut_rw.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and elaboration helpers for the runtime-writable palette.
package palette_pkg;

  typedef enum logic {IDLE = 1'b0, FADING = 1'b1} fade_state_t;

  // Brightness value that leaves colours unscaled.
  function automatic int unsigned unity_bright(input int unsigned bright_w);
    return 32'd1 << bright_w;
  endfunction

  // Grey-ramp level for entry i: spreads 0..2^index_w-1 evenly over 0..2^ch_w-1.
  function automatic int unsigned grey_level(input int unsigned i,
                                             input int unsigned index_w,
                                             input int unsigned ch_w);
    return (i * ((32'd1 << ch_w) - 1)) / ((32'd1 << index_w) - 1);
  endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Fade engine: brightness register stepped one unit every FADE_DIV cycles
// toward a latched target, with busy/done handshake.
module palette_fade_ctrl
  import palette_pkg::*;
#(
  parameter int BRIGHT_W = 4,
  parameter int FADE_DIV = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              fade_start,
  input  logic [BRIGHT_W:0] fade_target,
  output logic [BRIGHT_W:0] brightness,
  output logic              fade_busy,
  output logic              fade_done
);

  localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [BRIGHT_W:0] UNITY    = (BRIGHT_W+1)'(unity_bright(BRIGHT_W));
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(FADE_DIV - 1);

  fade_state_t       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BRIGHT_W:0] tgt_q, tgt_d, bri_q, bri_d, tgt_in;
  logic              done_q, done_d;

  // Out-of-range targets saturate at unity.
  assign tgt_in = (fade_target > UNITY) ? UNITY : fade_target;

  // Next-state: retarget has priority over a divider step in the same cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tgt_d   = tgt_q;
    bri_d   = bri_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fade_start) begin
          if (tgt_in == bri_q) begin
            done_d = 1'b1;
          end else begin
            state_d = FADING;
            div_d   = '0;
            tgt_d   = tgt_in;
          end
        end
      end
      FADING: begin
        if (fade_start) begin
          tgt_d = tgt_in;
          div_d = '0;
          if (tgt_in == bri_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          bri_d = (bri_q < tgt_q) ? bri_q + 1'b1 : bri_q - 1'b1;
          if (bri_d == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any fade without a done pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      tgt_q   <= UNITY;
      bri_q   <= UNITY;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tgt_q   <= tgt_d;
      bri_q   <= bri_d;
      done_q  <= done_d;
    end
  end

  assign brightness = bri_q;
  assign fade_busy  = (state_q == FADING);
  assign fade_done  = done_q;

endmodule

// File: rtl/palette_lut_rw.sv
// Writable colour palette with a 2-stage lookup and global brightness scaling.
// Optional macro PALETTE_TRANSPARENCY_EN adds the transparent-index flag.
module palette_lut_rw
  import palette_pkg::*;
#(
  parameter int INDEX_W           = 4,
  parameter int CH_W              = 4,
  parameter int BRIGHT_W          = 4,
  parameter int FADE_DIV          = 4,
  parameter int TRANSPARENT_INDEX = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                rd_valid_in,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0]   wr_rgb,
  input  logic                fade_start,
  input  logic [BRIGHT_W:0]   fade_target,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                rd_valid_out,
  output logic                transparent,
  output logic [BRIGHT_W:0]   brightness,
  output logic                fade_busy,
  output logic                fade_done
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int PROD_W  = CH_W + BRIGHT_W + 1;

  typedef logic [2:0][CH_W-1:0] rgb_t;   // [2]=r, [1]=g, [0]=b

  function automatic logic [ENTRIES-1:0][2:0][CH_W-1:0] build_ramp();
    logic [ENTRIES-1:0][2:0][CH_W-1:0] r;
    for (int i = 0; i < ENTRIES; i++)
      for (int c = 0; c < 3; c++)
        r[i][c] = CH_W'(grey_level(i, INDEX_W, CH_W));
    return r;
  endfunction

  localparam logic [ENTRIES-1:0][2:0][CH_W-1:0] RAMP = build_ramp();

  if (FADE_DIV < 1 || TRANSPARENT_INDEX < 0 || TRANSPARENT_INDEX >= ENTRIES) begin : g_bad_param
    $error("palette_lut_rw: FADE_DIV or TRANSPARENT_INDEX out of range");
  end

  logic [ENTRIES-1:0][2:0][CH_W-1:0] pal;
  rgb_t       s1_rgb, out_rgb, scaled;
  logic [2:1] vld_pipe;

  palette_fade_ctrl #(.BRIGHT_W(BRIGHT_W), .FADE_DIV(FADE_DIV)) u_fade (
    .Clk(Clk), .Reset(Reset),
    .fade_start(fade_start), .fade_target(fade_target),
    .brightness(brightness), .fade_busy(fade_busy), .fade_done(fade_done)
  );

  // Palette storage; reads in the same cycle see the pre-write entry.
  always_ff @(posedge Clk) begin
    if (Reset)      pal <= RAMP;
    else if (wr_en) pal[wr_index] <= rgb_t'(wr_rgb);
  end

  // Per-channel brightness scale; product cannot exceed 2^CH_W-1 since brightness <= unity.
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [PROD_W-1:0] prod;
    assign prod       = PROD_W'(s1_rgb[ch]) * PROD_W'(brightness);
    assign scaled[ch] = CH_W'(prod >> BRIGHT_W);
  end

  // Lookup pipeline: stage 1 reads the array, stage 2 scales and holds when idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe <= '0;
      s1_rgb   <= '0;
      out_rgb  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_valid_in};
      s1_rgb   <= pal[rd_index];
      if (vld_pipe[1]) out_rgb <= scaled;
    end
  end

  assign red          = out_rgb[2];
  assign green        = out_rgb[1];
  assign blue         = out_rgb[0];
  assign rd_valid_out = vld_pipe[2];

`ifdef PALETTE_TRANSPARENCY_EN
  logic s1_tr, tr_q;
  // Transparency flag follows the colour through the same two stages.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_tr <= 1'b0;
      tr_q  <= 1'b0;
    end else begin
      s1_tr <= (rd_index == INDEX_W'(TRANSPARENT_INDEX));
      if (vld_pipe[1]) tr_q <= s1_tr;
    end
  end
  assign transparent = tr_q;
`else
  assign transparent = 1'b0;
`endif

endmodule

// File: tb/tb_palette_lut_rw.sv
// Directed bench for palette_lut_rw (default parameters, FADE_DIV = 4).
module tb_palette_lut_rw;

  localparam int INDEX_W = 4, CH_W = 4, BRIGHT_W = 4, FADE_DIV = 4;
`ifdef PALETTE_TRANSPARENCY_EN
  localparam logic TR_EXP = 1'b1;
`else
  localparam logic TR_EXP = 1'b0;
`endif

  logic                Clk = 1'b0;
  logic                Reset, rd_valid_in, wr_en, fade_start;
  logic [INDEX_W-1:0]  rd_index, wr_index;
  logic [3*CH_W-1:0]   wr_rgb;
  logic [BRIGHT_W:0]   fade_target, brightness;
  logic [CH_W-1:0]     red, green, blue;
  logic                rd_valid_out, transparent, fade_busy, fade_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic seen;

  always #5 Clk = ~Clk;

  palette_lut_rw #(.INDEX_W(INDEX_W), .CH_W(CH_W), .BRIGHT_W(BRIGHT_W),
                   .FADE_DIV(FADE_DIV), .TRANSPARENT_INDEX(0)) dut (
    .Clk(Clk), .Reset(Reset), .rd_valid_in(rd_valid_in), .rd_index(rd_index),
    .wr_en(wr_en), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .fade_start(fade_start), .fade_target(fade_target),
    .red(red), .green(green), .blue(blue), .rd_valid_out(rd_valid_out),
    .transparent(transparent), .brightness(brightness),
    .fade_busy(fade_busy), .fade_done(fade_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1; rd_valid_in = 0; rd_index = 0; wr_en = 0; wr_index = 0;
    wr_rgb = 0; fade_start = 0; fade_target = 0;
    tick(); tick();
    Reset = 0;
    check("reset_rgb",   {red, green, blue}, 32'h000);
    check("reset_valid", rd_valid_out, 0);
    check("reset_transp", transparent, 0);
    check("reset_bright", brightness, 16);
    check("reset_busy_done", {fade_busy, fade_done}, 0);

    // Back-to-back reads of 15 then 5 from the grey ramp.
    rd_valid_in = 1; rd_index = 15; tick();
    rd_index = 5; tick();
    check("rd15_rgb", {red, green, blue}, 32'hFFF);
    check("rd15_valid", rd_valid_out, 1);
    rd_valid_in = 0; tick();
    check("rd5_rgb", {red, green, blue}, 32'h555);
    check("rd5_valid", rd_valid_out, 1);
    tick();
    check("idle_valid", rd_valid_out, 0);
    check("idle_hold_rgb", {red, green, blue}, 32'h555);

    // Same-cycle write/read of index 3 returns the old entry.
    wr_en = 1; wr_index = 3; wr_rgb = 12'hEBB; rd_valid_in = 1; rd_index = 3; tick();
    wr_en = 0; tick();
    check("collide_old", {red, green, blue}, 32'h333);
    rd_valid_in = 0; tick();
    check("after_write_new", {red, green, blue}, 32'hEBB);

    // Fade 16 -> 8: eight steps of four cycles.
    fade_start = 1; fade_target = 8; tick();
    fade_start = 0;
    check("fade8_busy", fade_busy, 1);
    cyc = 0;
    while (!fade_done && cyc < 200) begin tick(); cyc++; end
    check("fade8_cycles", cyc, 32);
    check("fade8_bright", brightness, 8);
    check("fade8_busy_at_done", fade_busy, 0);
    rd_valid_in = 1; rd_index = 3; tick();
    rd_valid_in = 0; tick();
    check("half_bright_rgb", {red, green, blue}, 32'h755);

    // Target above unity saturates at 16.
    fade_start = 1; fade_target = 20; tick();
    fade_start = 0; cyc = 0;
    while (!fade_done && cyc < 200) begin tick(); cyc++; end
    check("clamp_cycles", cyc, 32);
    check("clamp_bright", brightness, 16);

    // Full fade 16 -> 0: first step at T+4, done at T+64.
    fade_start = 1; fade_target = 0; tick();
    fade_start = 0;
    tick(); tick(); tick();
    check("fade0_prestep", brightness, 16);
    tick();
    check("fade0_step1", brightness, 15);
    cyc = 4;
    while (!fade_done && cyc < 300) begin tick(); cyc++; end
    check("fade0_cycles", cyc, 64);
    check("fade0_bright", brightness, 0);
    rd_valid_in = 1; rd_index = 15; tick();
    rd_valid_in = 0; tick();
    check("black_rgb", {red, green, blue}, 32'h000);

    // Start with target equal to brightness: done next cycle, never busy.
    fade_start = 1; fade_target = 0; tick();
    fade_start = 0;
    check("eq_start_done", {fade_busy, fade_done}, 32'h1);
    tick();
    check("eq_start_done_clear", fade_done, 0);

    // Mid-fade retarget to the current brightness.
    Reset = 1; tick(); Reset = 0;
    check("rst2_bright", brightness, 16);
    fade_start = 1; fade_target = 0; tick();
    fade_start = 0; cyc = 0;
    while (brightness != 12 && cyc < 100) begin tick(); cyc++; end
    check("reach12_cycles", cyc, 16);
    fade_start = 1; fade_target = 12; tick();
    fade_start = 0;
    check("retarget_done", {fade_busy, fade_done, brightness}, {2'b01, 5'd12});
    repeat (8) tick();
    check("retarget_hold", {fade_done, brightness}, {1'b0, 5'd12});

    // Reset in the middle of a fade.
    wr_en = 1; wr_index = 5; wr_rgb = 12'h123; tick(); wr_en = 0;
    fade_start = 1; fade_target = 0; tick();
    fade_start = 0;
    repeat (5) tick();
    check("midfade_bright", {fade_busy, brightness}, {1'b1, 5'd11});
    Reset = 1; tick();
    check("midrst_state", {fade_busy, fade_done, brightness}, {2'b00, 5'd16});
    Reset = 0; seen = 0;
    repeat (10) begin tick(); if (fade_done) seen = 1; end
    check("midrst_no_done", seen, 0);
    rd_valid_in = 1; rd_index = 5; tick();
    rd_valid_in = 0; tick();
    check("midrst_ramp", {red, green, blue}, 32'h555);

    // Transparent index 0 vs. ordinary index 1.
    rd_valid_in = 1; rd_index = 0; tick();
    rd_index = 1; tick();
    rd_valid_in = 0;
    check("transp_idx0", {rd_valid_out, transparent}, {1'b1, TR_EXP});
    tick();
    check("transp_idx1", {rd_valid_out, transparent, red}, {2'b10, 4'h1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
